md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with the HI/LO register pair, located in the E stage of the 5-stage MIPS pipeline.
- Sequences mult/multu/div/divu over a fixed number of cycles and executes mthi/mtlo in a single cycle.
- Supplies HI/LO to mfhi/mflo.
- Drives the Busy signal, and echoes Start, consumed by the hazard unit; the hazard unit stalls any mult/div-class instruction in D while Start|Busy.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- Start  in  1  one-cycle pulse from E-stage decode: launch op in MDOp
- MDOp  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
- A  in  32  forwarded rs value (E stage)
- B  in  32  forwarded rt value (E stage)
- Busy  out  1  operation in progress
- Start_o  out  1  registered-free copy of Start, fed to hazard unit Start input
- HI  out  32  HI register
- LO  out  32  LO register

Behaviour:
- Reset, asynchronous, effective immediately:
  - HI=LO=0, Busy=0, state IDLE, counter=0.
  - A reset mid-operation aborts the operation; HI/LO stay 0.
- States: IDLE, RUN.
- IDLE, Start=1, MDOp in 1..4, rising edge at end of cycle t:
  - A and B are captured and the 64-bit result is computed into internal pending registers resHI/resLO.
  - Counter is loaded with MULT_CYCLES or DIV_CYCLES (N); go to RUN.
  - Busy=1 in cycles t+1..t+N.
- RUN: the counter decrements each edge. At the edge ending cycle t+N (counter==1): HI<=resHI, LO<=resLO, go to IDLE, Busy=0 from cycle t+N+1.
- HI/LO are architecturally unchanged throughout RUN; mfhi/mflo in that window are prevented by the hazard stall.
- mthi/mtlo in IDLE (MDOp 5/6, Start ignored for these ops): HI<=A or LO<=A at the next edge; Busy stays 0.
- Start or MDOp 5/6 while in RUN:
  - Ignored; the hazard unit guarantees this never occurs.
  - Pending result and timing are unaffected.
- Start with MDOp 0 or 7: no effect.
- Arithmetic:
  - mult: signed 32x32 -> 64; {HI,LO}=product.
  - multu: unsigned 32x32 -> 64.
  - div: signed, quotient truncated toward zero. LO=quotient; HI=remainder with the sign of the dividend.
  - div special case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
- Divide by zero (B==0, div or divu): the full DIV_CYCLES busy sequence still runs; HI and LO are left unchanged at completion.
- Start_o = Start, combinational.
- Back-to-back operation: a new Start is accepted in the first cycle where Busy=0, i.e. cycle t+N+1.

Test Plan:
- Reset high mid-RUN (cycle t+2 of a mult) -> Busy=0, HI=LO=0 immediately; after release, an IDLE mult works normally.
- mult A=0xFFFFFFFF, B=0x00000002 -> Busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 -> Busy for exactly 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu A=7, B=2 -> LO=3, HI=1.
- div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload via mtlo A=0x1234 and mthi A=0x5678 -> LO=0x1234, HI=0x5678 after one edge, Busy never set.
  - Then div by B=0 -> Busy for 10 cycles; HI/LO remain 0x5678/0x1234.
- Start mult while Busy (div in progress) -> ignored; div result lands at the original t+N edge and no mult result appears.

Source files
------------

// File: rtl/md_unit_if.sv
// Bundles the E-stage operand/launch inputs and the busy/HI/LO outputs of the
// multiply/divide unit.
interface md_unit_if;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Start_o;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Start, MDOp, A, B,
    input  Busy, Start_o, HI, LO
  );

  modport slave (
    input  Start, MDOp, A, B,
    output Busy, Start_o, HI, LO
  );
endinterface

// File: rtl/md_unit.sv
// MIPS E-stage multiply/divide unit: computes the 64-bit result at launch and
// holds it pending for a fixed number of busy cycles before committing to HI/LO.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  md_unit_if.slave    bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  md_op_e           op;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      res_q, res_d;
  logic             res_we_q, res_we_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             capture;

  assign op = md_op_e'(bus.MDOp);

  // ---------------------------------------------------------------------------
  // Arithmetic datapath, evaluated on the launch operands
  // ---------------------------------------------------------------------------
  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic [31:0] div_b_u, a_mag, b_mag, sq_mag, sr_mag, sq, sr, uq, ur;
  logic        b_zero;

  assign b_zero = (bus.B == 32'd0);
  assign a_sx   = {{32{bus.A[31]}}, bus.A};
  assign b_sx   = {{32{bus.B[31]}}, bus.B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

  // A zero divisor is replaced by 1 so the dividers never see 0; the result is
  // discarded anyway because the write enable is cleared.
  assign div_b_u = b_zero ? 32'd1 : bus.B;
  assign uq      = bus.A / div_b_u;
  assign ur      = bus.A % div_b_u;

  // Signed divide on magnitudes. 0x80000000 / -1 falls out naturally: the
  // magnitude quotient 0x80000000 negates to itself and the remainder is 0.
  assign a_mag  = bus.A[31] ? -bus.A : bus.A;
  assign b_mag  = b_zero ? 32'd1 : (bus.B[31] ? -bus.B : bus.B);
  assign sq_mag = a_mag / b_mag;
  assign sr_mag = a_mag % b_mag;
  assign sq     = (bus.A[31] ^ bus.B[31]) ? -sq_mag : sq_mag;
  assign sr     = bus.A[31] ? -sr_mag : sr_mag;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    res_d    = prod_s;
    res_we_d = 1'b1;
    unique case (op)
      OP_MULTU: res_d = prod_u;
      OP_DIV: begin
        res_d    = {sr, sq};
        res_we_d = !b_zero;
      end
      OP_DIVU: begin
        res_d    = {ur, uq};
        res_we_d = !b_zero;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM and HI/LO next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      IDLE: begin
        if (bus.Start && (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU})) begin
          capture = 1'b1;
          state_d = RUN;
          cnt_d   = (op inside {OP_DIV, OP_DIVU}) ? CNT_W'(DIV_CYCLES)
                                                  : CNT_W'(MULT_CYCLES);
        end else if (op == OP_MTHI) begin
          hi_d = bus.A;
        end else if (op == OP_MTLO) begin
          lo_d = bus.A;
        end
      end

      RUN: begin
        // New launches and mthi/mtlo are ignored here; the hazard unit keeps
        // them out, and the pending result must not be disturbed.
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (res_we_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the pending result registers are cleared on reset along with the
    // architectural state, so an aborted operation can never leak into HI/LO.
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      res_q    <= '0;
      res_we_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (capture) begin
        res_q    <= res_d;
        res_we_q <= res_we_d;
      end
    end
  end

  assign bus.Busy    = (state_q == RUN);
  assign bus.Start_o = bus.Start;
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed test-plan cases with literal
// expectations, then randomized traffic compared every cycle to a cycle-level model.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;

  md_unit_if bus ();

  md_unit #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;
  bit drv_start = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: plain 64-bit arithmetic plus one pending-result record
  // that lands at a known cycle number.
  // ---------------------------------------------------------------------------
  function automatic void model_op(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b,
                                   output bit we, output logic [63:0] r);
    longint sa, sb, ua, ub, q, rm;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    we = 1'b1;
    r  = '0;
    case (op)
      3'd1: r = sa * sb;
      3'd2: r = ua * ub;
      3'd3: if (b == 0) we = 1'b0;
            else begin q = sa / sb; rm = sa % sb; r = {rm[31:0], q[31:0]}; end
      3'd4: if (b == 0) we = 1'b0;
            else begin q = ua / ub; rm = ua % ub; r = {rm[31:0], q[31:0]}; end
      default: we = 1'b0;
    endcase
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0;
  bit          m_pend = 1'b0;
  bit          m_we = 1'b0;
  logic [63:0] m_res = '0;
  longint      m_cyc = 0, m_done = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_pend <= 1'b0;
    end else begin
      if (m_pend) begin
        if (m_cyc == m_done) begin
          if (m_we) begin
            m_hi <= m_res[63:32];
            m_lo <= m_res[31:0];
          end
          m_pend <= 1'b0;
        end
      end else if (bus.Start && bus.MDOp >= 3'd1 && bus.MDOp <= 3'd4) begin
        bit          we;
        logic [63:0] r;
        model_op(bus.MDOp, bus.A, bus.B, we, r);
        m_we   <= we;
        m_res  <= r;
        m_pend <= 1'b1;
        m_done <= m_cyc + ((bus.MDOp >= 3'd3) ? DIV_N : MULT_N);
      end else if (bus.MDOp == 3'd5) begin
        m_hi <= bus.A;
      end else if (bus.MDOp == 3'd6) begin
        m_lo <= bus.A;
      end
      m_cyc <= m_cyc + 1;
    end
  end

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("busy", 64'(bus.Busy), 64'(m_pend));
      check("hi", 64'(bus.HI), 64'(m_hi));
      check("lo", 64'(bus.LO), 64'(m_lo));
      check("start_o", 64'(bus.Start_o), 64'(drv_start));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step(input bit st, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    @(posedge clk);
    #1;
    drv_start = st;
    bus.Start = st;
    bus.MDOp  = op;
    bus.A     = a;
    bus.B     = b;
  endtask

  // Launch one op and count busy cycles; returns at the first idle cycle after.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int exp_n, input string name);
    int cnt = 0;
    bit done = 1'b0;
    step(1'b1, op, a, b);
    step(1'b0, 3'd0, '0, '0);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.Busy) cnt++;
      else done = 1'b1;
    end
    check({name, "_busy_cycles"}, 64'(cnt), 64'(exp_n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    bus.Start = 1'b0;
    bus.MDOp  = 3'd0;
    bus.A     = '0;
    bus.B     = '0;

    @(negedge clk);
    check("reset_busy", 64'(bus.Busy), 64'd0);
    check("reset_hi", 64'(bus.HI), 64'd0);
    check("reset_lo", 64'(bus.LO), 64'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    cmp_en = 1'b1;

    issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, MULT_N, "mult");
    check("mult_hi", 64'(bus.HI), 64'hFFFF_FFFF);
    check("mult_lo", 64'(bus.LO), 64'hFFFF_FFFE);

    issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, MULT_N, "multu");
    check("multu_hi", 64'(bus.HI), 64'h0000_0001);
    check("multu_lo", 64'(bus.LO), 64'hFFFF_FFFE);

    issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, DIV_N, "div");
    check("div_hi", 64'(bus.HI), 64'hFFFF_FFFF);
    check("div_lo", 64'(bus.LO), 64'hFFFF_FFFD);

    issue(3'd4, 32'd7, 32'd2, DIV_N, "divu");
    check("divu_hi", 64'(bus.HI), 64'd1);
    check("divu_lo", 64'(bus.LO), 64'd3);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, "div_ovf");
    check("div_ovf_hi", 64'(bus.HI), 64'd0);
    check("div_ovf_lo", 64'(bus.LO), 64'h8000_0000);

    // mthi/mtlo preload, one with Start set to show Start is irrelevant for them
    step(1'b0, 3'd6, 32'h0000_1234, '0);
    step(1'b1, 3'd5, 32'h0000_5678, '0);
    step(1'b0, 3'd0, '0, '0);
    @(negedge clk);
    check("mt_lo", 64'(bus.LO), 64'h1234);
    check("mt_hi", 64'(bus.HI), 64'h5678);
    check("mt_busy", 64'(bus.Busy), 64'd0);

    issue(3'd3, 32'd99, 32'd0, DIV_N, "div0");
    check("div0_hi", 64'(bus.HI), 64'h5678);
    check("div0_lo", 64'(bus.LO), 64'h1234);

    // mult launched while a div is running must be ignored
    begin
      bit idle = 1'b0;
      step(1'b1, 3'd3, 32'd100, 32'd7);
      step(1'b0, 3'd0, '0, '0);
      repeat (3) @(negedge clk);
      step(1'b1, 3'd1, 32'd5, 32'd5);
      step(1'b0, 3'd0, '0, '0);
      for (int i = 0; i < 40 && !idle; i++) begin
        @(negedge clk);
        if (!bus.Busy) idle = 1'b1;
      end
      check("ign_idle", 64'(idle), 64'd1);
      check("ign_hi", 64'(bus.HI), 64'd2);
      check("ign_lo", 64'(bus.LO), 64'd14);
      repeat (8) @(negedge clk);
      check("ign_hi_late", 64'(bus.HI), 64'd2);
      check("ign_lo_late", 64'(bus.LO), 64'd14);
    end

    // asynchronous reset in the middle of a mult
    step(1'b1, 3'd1, 32'd3, 32'd4);
    step(1'b0, 3'd0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_busy", 64'(bus.Busy), 64'd0);
    check("midrst_hi", 64'(bus.HI), 64'd0);
    check("midrst_lo", 64'(bus.LO), 64'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    issue(3'd1, 32'd3, 32'd4, MULT_N, "post_rst_mult");
    check("post_rst_hi", 64'(bus.HI), 64'd0);
    check("post_rst_lo", 64'(bus.LO), 64'd12);

    // randomized traffic, including launches and mthi/mtlo during RUN
    for (int i = 0; i < 500; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        default: b = 32'($urandom);
      endcase
      step($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), a, b);
    end
    for (int i = 0; i < DIV_N + 3; i++) step(1'b0, 3'd0, '0, '0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
